// File: rtl/layer_state_seq.sv
`default_nettype none
// ============================================================================
// Module   : layer_state_seq
// Purpose  : Layer-level sequencer that drives current_state to the feature-map
//            controller and weight memory. Optional build macro
//            LAYER_SEQ_PERF_CNT_EN adds the 32-bit active_cycles counter.
// Revision : 1.0
// ============================================================================
module layer_state_seq #(
  parameter int unsigned LAYER_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic               wt_load_done,
  input  logic               fm_state_rst,
  output logic [2:0]         current_state,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               bank_sel,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef LAYER_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        active_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_CONV   = 3'd2,
    S_WRBACK = 3'd3,
    S_SWAP   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  // Expiry is flagged on the last permitted cycle so the state spends exactly
  // TIMEOUT_CYCLES cycles waiting before ERR appears.
  localparam logic [TO_W-1:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic            WD_EN   = (TIMEOUT_CYCLES != 0);

  state_t             state, state_nxt;
  logic [TO_W-1:0]    wdog, wdog_nxt;
  logic [LAYER_W-1:0] count, count_nxt;
  logic [LAYER_W-1:0] idx_nxt;
  logic               bank_nxt;
  logic               start_acc;
  logic               wait_state;
  logic               wd_expire;

  assign current_state = state;
  assign wait_state    = (state == S_LOAD_W) || (state == S_CONV) || (state == S_WRBACK);
  assign wd_expire     = WD_EN && (wdog == WD_LAST);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    idx_nxt   = layer_idx;
    bank_nxt  = bank_sel;
    start_acc = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            start_acc = 1'b1;
            count_nxt = num_layers;
            idx_nxt   = '0;
            bank_nxt  = 1'b0;
            state_nxt = (num_layers != '0) ? S_LOAD_W : S_DONE;
          end
        end
        S_LOAD_W: begin
          if (wt_load_done)   state_nxt = S_CONV;
          else if (wd_expire) state_nxt = S_ERR;
        end
        S_CONV: begin
          if (fm_state_rst)   state_nxt = S_WRBACK;
          else if (wd_expire) state_nxt = S_ERR;
        end
        S_WRBACK: begin
          if (fm_state_rst)   state_nxt = S_SWAP;
          else if (wd_expire) state_nxt = S_ERR;
        end
        S_SWAP: begin
          bank_nxt = ~bank_sel;
          // Compare before incrementing so the index never wraps past the count.
          if (layer_idx == count - LAYER_W'(1)) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = layer_idx + LAYER_W'(1);
            state_nxt = S_LOAD_W;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        S_ERR:   state_nxt = S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
    wdog_nxt = (wait_state && (state_nxt == state)) ? wdog + TO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wdog      <= '0;
      count     <= '0;
      layer_idx <= '0;
      bank_sel  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      wdog      <= wdog_nxt;
      count     <= count_nxt;
      layer_idx <= idx_nxt;
      bank_sel  <= bank_nxt;
      busy      <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERR));
      done      <= (state_nxt == S_DONE);
      err       <= (state_nxt == S_ERR);
    end
  end

`ifdef LAYER_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      active_cycles <= '0;
    end else if (((state == S_CONV) || (state == S_WRBACK)) && (active_cycles != 32'hFFFF_FFFF)) begin
      active_cycles <= active_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_state_seq.sv
`default_nettype none
// Self-checking bench for layer_state_seq: directed scenarios plus randomized
// runs compared against a transaction-level expectation of each layer run.
module tb_layer_state_seq;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] num_layers = '0;
  logic          wt_load_done = 1'b0;
  logic          fm_state_rst = 1'b0;
  logic [2:0]    current_state;
  logic [LW-1:0] layer_idx;
  logic          bank_sel, busy, done, err;
`ifdef LAYER_SEQ_PERF_CNT_EN
  logic [31:0]   active_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  layer_state_seq #(.LAYER_W(LW), .TIMEOUT_CYCLES(20), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_layers(num_layers),
    .wt_load_done(wt_load_done), .fm_state_rst(fm_state_rst),
    .current_state(current_state), .layer_idx(layer_idx), .bank_sel(bank_sel),
    .busy(busy), .done(done), .err(err)
`ifdef LAYER_SEQ_PERF_CNT_EN
    , .active_cycles(active_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spend exactly d cycles in state st; the awaited pulse goes out on the last one.
  task automatic stay(input logic [2:0] st, input int d, input bit stray, input string tag);
    for (int k = 1; k <= d; k++) begin
      n_checks++;
      if (current_state !== st) begin
        n_fail++;
        $display("FAIL %s_hold cyc%0d: state=%0d expected %0d", tag, k, current_state, st);
      end
      if (k == d) begin
        if (st == 3'd1) wt_load_done = 1'b1;
        else            fm_state_rst = 1'b1;
      end else if (stray && k == 1) begin
        if (st == 3'd1) fm_state_rst = 1'b1;
        else            wt_load_done = 1'b1;
        start      = 1'b1;
        num_layers = 4'd7;
      end
      step();
      wt_load_done = 1'b0;
      fm_state_rst = 1'b0;
      start        = 1'b0;
    end
  endtask

  // Whole run: expected per-layer index/bank and total CONV+WRBACK residency.
  task automatic run_layers(input int n, input bit rnd, input bit stray, input string tag);
    int  d;
    longint act = 0;
    num_layers = LW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    num_layers = LW'($urandom);
    for (int l = 0; l < n; l++) begin
      n_checks++;
      if (current_state !== 3'd1 || layer_idx !== LW'(l) || bank_sel !== l[0] || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_layer%0d_entry: st=%0d idx=%0d bank=%0d busy=%0d done=%0d expected st=1 idx=%0d bank=%0d busy=1 done=0",
                 tag, l, current_state, layer_idx, bank_sel, busy, done, l, l[0]);
      end
      d = rnd ? int'($urandom_range(1, 20)) : 5;
      stay(3'd1, d, stray, tag);
      d = rnd ? int'($urandom_range(1, 20)) : 10;
      act += d;
      stay(3'd2, d, stray, tag);
      d = rnd ? int'($urandom_range(1, 20)) : 10;
      act += d;
      stay(3'd3, d, stray, tag);
      n_checks++;
      if (current_state !== 3'd4 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_swap%0d: st=%0d busy=%0d expected st=4 busy=1", tag, l, current_state, busy);
      end
      step();
    end
    n_checks++;
    if (current_state !== 3'd5 || done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 ||
        layer_idx !== LW'(n - 1) || bank_sel !== n[0]) begin
      n_fail++;
      $display("FAIL %s_done: st=%0d done=%0d busy=%0d err=%0d idx=%0d bank=%0d expected st=5 done=1 busy=0 err=0 idx=%0d bank=%0d",
               tag, current_state, done, busy, err, layer_idx, bank_sel, n - 1, n[0]);
    end
`ifdef LAYER_SEQ_PERF_CNT_EN
    n_checks++;
    if (active_cycles !== act[31:0]) begin
      n_fail++;
      $display("FAIL %s_active_cycles: got %0d expected %0d", tag, active_cycles, act);
    end
`endif
    step();
    n_checks++;
    if (current_state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_after: st=%0d done=%0d busy=%0d expected 0 0 0", tag, current_state, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (current_state !== 3'd0 || layer_idx !== '0 || bank_sel !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: st=%0d idx=%0d bank=%0d busy=%0d done=%0d err=%0d expected all 0",
               current_state, layer_idx, bank_sel, busy, done, err);
    end
  endtask

  task automatic test_zero_layers();
    num_layers = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (current_state !== 3'd5 || done !== 1'b1 || busy !== 1'b0 || layer_idx !== '0) begin
      n_fail++;
      $display("FAIL zero_done: st=%0d done=%0d busy=%0d idx=%0d expected st=5 done=1 busy=0 idx=0",
               current_state, done, busy, layer_idx);
    end
`ifdef LAYER_SEQ_PERF_CNT_EN
    n_checks++;
    if (active_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_active_cycles: got %0d expected 0", active_cycles);
    end
`endif
    step();
    n_checks++;
    if (current_state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: st=%0d done=%0d busy=%0d expected 0 0 0", current_state, done, busy);
    end
  endtask

  task automatic test_watchdog();
    num_layers = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      n_checks++;
      if (current_state !== 3'd1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL wdog_wait cyc%0d: st=%0d err=%0d expected st=1 err=0", k, current_state, err);
      end
      step();
    end
    n_checks++;
    if (current_state !== 3'd7 || err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_err: st=%0d err=%0d busy=%0d expected st=7 err=1 busy=0", current_state, err, busy);
    end
    num_layers = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (current_state !== 3'd7 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_start_ignored: st=%0d err=%0d expected st=7 err=1", current_state, err);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (current_state !== 3'd0 || err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_abort: st=%0d err=%0d busy=%0d done=%0d expected all 0", current_state, err, busy, done);
    end
  endtask

  task automatic test_simultaneous();
    num_layers = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    stay(3'd1, 3, 1'b0, "simul");
    stay(3'd2, 20, 1'b0, "simul");
    n_checks++;
    if (current_state !== 3'd3 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_pulse_at_expiry: st=%0d err=%0d expected st=3 err=0", current_state, err);
    end
    stay(3'd3, 2, 1'b0, "simul");
    step();
    step();
    abort = 1'b1;
    start = 1'b1;
    num_layers = 4'd2;
    step();
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if (current_state !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_abort_start: st=%0d busy=%0d expected st=0 busy=0", current_state, busy);
    end
  endtask

  task automatic test_abort_midrun();
    num_layers = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    stay(3'd1, 2, 1'b0, "abort");
    stay(3'd2, 2, 1'b0, "abort");
    stay(3'd3, 2, 1'b0, "abort");
    step();
    stay(3'd1, 2, 1'b0, "abort");
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (current_state !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || layer_idx !== LW'(1) || bank_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_midrun: st=%0d busy=%0d done=%0d idx=%0d bank=%0d expected st=0 busy=0 done=0 idx=1 bank=1",
               current_state, busy, done, layer_idx, bank_sel);
    end
  endtask

  task automatic test_reset_midrun();
    num_layers = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    stay(3'd1, 2, 1'b0, "rstmid");
    stay(3'd2, 3, 1'b0, "rstmid");
    stay(3'd3, 3, 1'b0, "rstmid");
    step();
    stay(3'd1, 2, 1'b0, "rstmid");
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (current_state !== 3'd0 || layer_idx !== '0 || bank_sel !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_values: st=%0d idx=%0d bank=%0d busy=%0d done=%0d err=%0d expected all 0",
               current_state, layer_idx, bank_sel, busy, done, err);
    end
`ifdef LAYER_SEQ_PERF_CNT_EN
    n_checks++;
    if (active_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_active_cycles: got %0d expected 0", active_cycles);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (done !== 1'b0 || current_state !== 3'd0) begin
        n_fail++;
        $display("FAIL rstmid_no_done cyc%0d: done=%0d st=%0d expected done=0 st=0", k, done, current_state);
      end
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      run_layers(int'($urandom_range(1, 6)), 1'b1, r[0], "random");
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end
  endtask

  initial begin
    test_reset();
    run_layers(3, 1'b0, 1'b0, "three_layer");
    test_zero_layers();
    test_watchdog();
    test_simultaneous();
    run_layers(3, 1'b0, 1'b1, "stray_busy_start");
    test_abort_midrun();
    test_reset_midrun();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
